// File: rtl/wb_daq_data_packer.sv
`default_nettype none
// ============================================================================
// Module   : wb_daq_data_packer
// Purpose  : Packs 8/16/32-bit ADC samples little-endian into DW-bit FIFO
//            words. One-word output stage with FIFO back-pressure, explicit
//            flush, auto-flush on sample-width change, per-byte valid mask,
//            sticky overflow flag and saturating drop counter.
// Ports    : wb_clk, wb_rst_n (async active-low)
//            enable, data_ready, data_width[1:0], adc_data_in[ADC_DW]  - sample in
//            flush                                                     - emit partial word
//            fifo_full / fifo_push, data_out[DW], byte_valid[DW/8]     - FIFO side
//            clear_overflow, overflow, drop_count[CNT_W]               - drop reporting
// Revision : 1.0 - initial release
// ============================================================================
module wb_daq_data_packer #(
    parameter int DW     = 32,
    parameter int ADC_DW = 32,
    parameter int CNT_W  = 16
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic              enable,
    input  logic              data_ready,
    input  logic [1:0]        data_width,
    input  logic [ADC_DW-1:0] adc_data_in,
    input  logic              flush,
    input  logic              fifo_full,
    input  logic              clear_overflow,
    output logic [DW-1:0]     data_out,
    output logic [DW/8-1:0]   byte_valid,
    output logic              fifo_push,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int NB = DW / 8;             // bytes per word
    localparam int PW = $clog2(NB) + 1;     // byte_ptr must be able to hold NB

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0]    r_acc;
    logic [PW-1:0]    r_byte_ptr;           // valid bytes in r_acc
    logic             r_acc_full;           // r_acc holds a finished word waiting for the stage
    logic [1:0]       r_cur_width;
    logic             r_out_valid;
    logic [DW-1:0]    r_data_out;
    logic [NB-1:0]    r_byte_valid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    // ------------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------------
    logic             w_push;
    logic             w_stage_free;
    logic             w_sample_valid;
    logic [DW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_ptr_nxt;
    logic             w_full_nxt;
    logic             w_load;
    logic [DW-1:0]    w_load_data;
    logic [NB-1:0]    w_load_mask;
    logic             w_drop;
    logic             w_blocked;
    logic [DW-1:0]    w_work_acc;
    int               w_p;
    int               w_sb;

    // Mask with the lowest n bytes set.
    function automatic logic [NB-1:0] mask_of(input int n);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    assign w_push         = r_out_valid & ~fifo_full;
    // The stage can take a word if empty or if it is being drained this cycle.
    assign w_stage_free   = ~r_out_valid | w_push;
    assign w_sample_valid = data_ready & enable & (data_width != 2'd3);

    always_comb begin
        w_acc_nxt   = r_acc;
        w_ptr_nxt   = r_byte_ptr;
        w_full_nxt  = r_acc_full;
        w_load      = 1'b0;
        w_load_data = r_acc;
        w_load_mask = '0;
        w_drop      = 1'b0;
        w_blocked   = 1'b0;
        w_work_acc  = r_acc;
        w_p         = int'(r_byte_ptr);
        w_sb        = 1 << data_width;

        if (r_acc_full) begin
            // A finished word is parked; every incoming sample is lost and
            // flush has nothing new to emit.
            w_drop = w_sample_valid;
            if (w_stage_free) begin
                w_load      = 1'b1;
                w_load_data = r_acc;
                w_load_mask = mask_of(w_p);
                w_acc_nxt   = '0;
                w_ptr_nxt   = '0;
                w_full_nxt  = 1'b0;
            end
        end else begin
            // Width change with a partial word pending: push the partial
            // word out before the new sample is written at byte 0.
            if (w_sample_valid && (data_width != r_cur_width) && (w_p != 0)) begin
                if (w_stage_free) begin
                    w_load      = 1'b1;
                    w_load_data = r_acc;
                    w_load_mask = mask_of(w_p);
                    w_work_acc  = '0;
                    w_p         = 0;
                end else begin
                    // Partial word parks in acc; the new sample has no room.
                    w_full_nxt = 1'b1;
                    w_drop     = 1'b1;
                    w_blocked  = 1'b1;
                end
            end

            if (!w_blocked) begin
                if (w_sample_valid) begin
                    // Same-width samples stay naturally aligned, so the
                    // write never runs past the end of the word.
                    for (int i = 0; i < NB; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            if ((j < w_sb) && (i == w_p + j)) begin
                                w_work_acc[8*i +: 8] = adc_data_in[8*j +: 8];
                            end
                        end
                    end
                    w_p = w_p + w_sb;
                end

                if ((w_p == NB) || (flush && (w_p != 0))) begin
                    // Word is complete or flushed; it only goes straight to
                    // the stage if the stage was not already refilled above.
                    if (w_stage_free && !w_load) begin
                        w_load      = 1'b1;
                        w_load_data = w_work_acc;
                        w_load_mask = mask_of(w_p);
                        w_acc_nxt   = '0;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_acc_nxt  = w_work_acc;
                        w_ptr_nxt  = PW'(w_p);
                        w_full_nxt = 1'b1;
                    end
                end else begin
                    w_acc_nxt = w_work_acc;
                    w_ptr_nxt = PW'(w_p);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_acc       <= '0;
            r_byte_ptr  <= '0;
            r_acc_full  <= 1'b0;
            r_cur_width <= 2'd0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_byte_ptr <= w_ptr_nxt;
            r_acc_full <= w_full_nxt;
            if (w_sample_valid && !r_acc_full) begin
                r_cur_width <= data_width;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: holds data_out/byte_valid stable until pushed
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_out_valid  <= 1'b0;
            r_data_out   <= '0;
            r_byte_valid <= '0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_data_out   <= w_load_data;
            r_byte_valid <= w_load_mask;
        end else if (w_push) begin
            r_out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Drop reporting; a drop coinciding with clear counts as the first drop
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_overflow) begin
            r_overflow   <= w_drop;
            r_drop_count <= w_drop ? CNT_W'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (!(&r_drop_count)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign data_out   = r_data_out;
    assign byte_valid = r_byte_valid;
    assign fifo_push  = w_push;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_daq_data_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_daq_data_packer
// Purpose  : Self-checking bench for wb_daq_data_packer (DW=32): table of
//            per-cycle vectors, hand sequences for back-pressure / clear /
//            reset, and a randomized run against a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_daq_data_packer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        data_ready;
    logic [1:0]  data_width;
    logic [31:0] adc_data_in;
    logic        flush;
    logic        fifo_full;
    logic        clear_overflow;
    logic [31:0] data_out;
    logic [3:0]  byte_valid;
    logic        fifo_push;
    logic        overflow;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    wb_daq_data_packer #(.DW(32), .ADC_DW(32), .CNT_W(16)) dut (
        .wb_clk         (clk),
        .wb_rst_n       (rst_n),
        .enable         (enable),
        .data_ready     (data_ready),
        .data_width     (data_width),
        .adc_data_in    (adc_data_in),
        .flush          (flush),
        .fifo_full      (fifo_full),
        .clear_overflow (clear_overflow),
        .data_out       (data_out),
        .byte_valid     (byte_valid),
        .fifo_push      (fifo_push),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        dr;
        logic [1:0]  w;
        logic [31:0] d;
        logic        fl;
        logic        push;
        logic [31:0] dout;
        logic [3:0]  mask;
    } vec_t;

    vec_t tv[$];

    // Reference model state (byte queue abstraction of the packer)
    logic [7:0]  m_bytes[$];
    logic [1:0]  m_cur;
    logic        m_hold;
    int          m_drops;
    logic        model_on = 1'b0;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    logic        mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic dr, input logic [1:0] w, input logic [31:0] d,
                       input logic fl, input logic push, input logic [31:0] dout, input logic [3:0] mask);
        vec_t v;
        v.en = en; v.dr = dr; v.w = w; v.d = d; v.fl = fl;
        v.push = push; v.dout = dout; v.mask = mask;
        tv.push_back(v);
    endtask

    // Emit the model's current byte list as one word.
    task automatic m_emit();
        logic [31:0] word;
        logic [3:0]  mask;
        word = '0;
        mask = '0;
        for (int k = 0; k < m_bytes.size(); k++) begin
            word[8*k +: 8] = m_bytes[k];
            mask[k]        = 1'b1;
        end
        exp_q.push_back({word, mask});
        m_bytes.delete();
    endtask

    // One cycle of the reference model (fifo_full assumed 0).
    task automatic m_step(input logic en, input logic dr, input logic [1:0] w,
                          input logic [31:0] d, input logic fl);
        logic valid;
        int   nwords;
        int   sb;
        valid = dr && en && (w != 2'd3);
        if (m_hold) begin
            // Second word of the previous cycle is still waiting for the stage.
            if (valid) m_drops++;
            m_hold = 1'b0;
        end else begin
            nwords = 0;
            if (valid && (w != m_cur) && (m_bytes.size() != 0)) begin
                m_emit();
                nwords++;
            end
            if (valid) begin
                sb = 1 << w;
                for (int j = 0; j < sb; j++) m_bytes.push_back(d[8*j +: 8]);
                m_cur = w;
            end
            if ((m_bytes.size() == 4) || (fl && (m_bytes.size() != 0))) begin
                m_emit();
                nwords++;
            end
            m_hold = (nwords == 2);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
    task automatic cyc(input logic en, input logic dr, input logic [1:0] w, input logic [31:0] d,
                       input logic fl, input logic ff, input logic clr);
        @(posedge clk);
        #1;
        enable = en; data_ready = dr; data_width = w; adc_data_in = d;
        flush = fl; fifo_full = ff; clear_overflow = clr;
        if (model_on) m_step(en, dr, w, d, fl);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on && fifo_push) got_q.push_back({data_out, byte_valid});
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; data_ready = 1'b0; data_width = 2'd0;
        adc_data_in = '0; flush = 1'b0; fifo_full = 1'b0; clear_overflow = 1'b0;

        //               en dr w  data           fl  push dout           mask
        add(1, 1, 0, 32'h11,       0,  0, 32'h0,        4'h0);
        add(1, 1, 0, 32'h22,       0,  0, 32'h0,        4'h0);
        add(1, 1, 0, 32'h33,       0,  0, 32'h0,        4'h0);
        add(1, 1, 0, 32'h44,       0,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        0,  1, 32'h44332211, 4'hF);
        add(1, 1, 1, 32'hAAAA,     0,  0, 32'h0,        4'h0);
        add(1, 1, 1, 32'hBBBB,     0,  0, 32'h0,        4'h0);
        add(1, 1, 1, 32'hCCCC,     0,  1, 32'hBBBBAAAA, 4'hF);
        add(1, 1, 1, 32'hDDDD,     0,  0, 32'h0,        4'h0);
        add(1, 0, 1, 32'h0,        0,  1, 32'hDDDDCCCC, 4'hF);
        add(1, 1, 0, 32'h01,       0,  0, 32'h0,        4'h0);
        add(1, 1, 0, 32'h02,       0,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        1,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        1,  1, 32'h00000201, 4'h3);
        add(1, 0, 0, 32'h0,        0,  0, 32'h0,        4'h0);
        add(1, 1, 0, 32'h55,       0,  0, 32'h0,        4'h0);
        add(1, 1, 2, 32'h12345678, 0,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        0,  1, 32'h00000055, 4'h1);
        add(1, 0, 0, 32'h0,        0,  1, 32'h12345678, 4'hF);
        add(1, 0, 0, 32'h0,        0,  0, 32'h0,        4'h0);
        add(0, 1, 0, 32'hEE,       0,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        1,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        0,  0, 32'h0,        4'h0);
        add(1, 1, 3, 32'h77,       0,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        1,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        0,  0, 32'h0,        4'h0);
        add(1, 1, 1, 32'h1234,     0,  0, 32'h0,        4'h0);
        add(1, 1, 1, 32'h5678,     1,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        0,  1, 32'h56781234, 4'hF);
        add(1, 0, 0, 32'h0,        0,  0, 32'h0,        4'h0);
        add(1, 1, 0, 32'hAB,       1,  0, 32'h0,        4'h0);
        add(1, 0, 0, 32'h0,        0,  1, 32'h000000AB, 4'h1);
        add(1, 0, 0, 32'h0,        0,  0, 32'h0,        4'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_push", 32'(fifo_push), 32'h0);
        chk("rst_dout", data_out, 32'h0);
        chk("rst_mask", 32'(byte_valid), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_cnt", 32'(drop_count), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven per-cycle vectors
        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].en, tv[i].dr, tv[i].w, tv[i].d, tv[i].fl, 1'b0, 1'b0);
            chk($sformatf("tv%0d_push", i), 32'(fifo_push), 32'(tv[i].push));
            if (tv[i].push) begin
                chk($sformatf("tv%0d_dout", i), data_out, tv[i].dout);
                chk($sformatf("tv%0d_mask", i), 32'(byte_valid), 32'(tv[i].mask));
            end
        end

        // Back-pressure: stage holds 1, acc parks 2, samples 3 and 4 dropped
        cyc(1, 1, 2, 32'h1, 0, 1, 0); chk("bp_push_a", 32'(fifo_push), 32'h0);
        cyc(1, 1, 2, 32'h2, 0, 1, 0); chk("bp_push_b", 32'(fifo_push), 32'h0);
        chk("bp_dout_b", data_out, 32'h1); chk("bp_mask_b", 32'(byte_valid), 32'hF);
        cyc(1, 1, 2, 32'h3, 0, 1, 0); chk("bp_dout_c", data_out, 32'h1);
        chk("bp_ovf_c", 32'(overflow), 32'h0);
        cyc(1, 1, 2, 32'h4, 0, 1, 0); chk("bp_ovf_d", 32'(overflow), 32'h1);
        chk("bp_cnt_d", 32'(drop_count), 32'h1);
        cyc(1, 0, 2, 32'h0, 0, 1, 0); chk("bp_cnt_e", 32'(drop_count), 32'h2);
        chk("bp_push_e", 32'(fifo_push), 32'h0); chk("bp_dout_e", data_out, 32'h1);
        cyc(1, 0, 2, 32'h0, 0, 0, 0); chk("bp_push_f", 32'(fifo_push), 32'h1);
        chk("bp_dout_f", data_out, 32'h1);
        cyc(1, 0, 2, 32'h0, 0, 0, 0); chk("bp_push_g", 32'(fifo_push), 32'h1);
        chk("bp_dout_g", data_out, 32'h2); chk("bp_mask_g", 32'(byte_valid), 32'hF);
        cyc(1, 0, 2, 32'h0, 0, 0, 1); chk("bp_push_h", 32'(fifo_push), 32'h0);
        cyc(1, 0, 2, 32'h0, 0, 0, 0); chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_cnt", 32'(drop_count), 32'h0);

        // Clear coinciding with a drop restarts the count at one
        cyc(1, 1, 2, 32'h5, 0, 1, 0);
        cyc(1, 1, 2, 32'h6, 0, 1, 0);
        cyc(1, 1, 2, 32'h7, 0, 1, 0);
        cyc(1, 1, 2, 32'h8, 0, 1, 0); chk("cd_cnt_m", 32'(drop_count), 32'h1);
        cyc(1, 1, 2, 32'h9, 0, 1, 1); chk("cd_cnt_n", 32'(drop_count), 32'h2);
        cyc(1, 0, 2, 32'h0, 0, 1, 0); chk("cd_cnt_o", 32'(drop_count), 32'h1);
        chk("cd_ovf_o", 32'(overflow), 32'h1);
        cyc(1, 0, 2, 32'h0, 0, 0, 0); chk("cd_dout_p", data_out, 32'h5);
        chk("cd_push_p", 32'(fifo_push), 32'h1);
        cyc(1, 0, 2, 32'h0, 0, 0, 0); chk("cd_dout_q", data_out, 32'h6);
        chk("cd_push_q", 32'(fifo_push), 32'h1);
        cyc(1, 0, 2, 32'h0, 0, 0, 0); chk("cd_push_r", 32'(fifo_push), 32'h0);

        // Reset mid-word with a word waiting in the output stage
        cyc(1, 1, 2, 32'hAABBCCDD, 0, 1, 0);
        cyc(1, 1, 0, 32'h33, 0, 1, 0); chk("mr_dout", data_out, 32'hAABBCCDD);
        @(posedge clk);
        #1 data_ready = 1'b0; fifo_full = 1'b0;
        #1 chk("mr_push_pre", 32'(fifo_push), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("mr_push", 32'(fifo_push), 32'h0);
        chk("mr_dout0", data_out, 32'h0); chk("mr_mask0", 32'(byte_valid), 32'h0);
        chk("mr_ovf0", 32'(overflow), 32'h0); chk("mr_cnt0", 32'(drop_count), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 1, 0, 32'h9A, 0, 0, 0);
        cyc(1, 0, 0, 32'h0, 1, 0, 0); chk("mr_push_f", 32'(fifo_push), 32'h0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0); chk("mr_push_9a", 32'(fifo_push), 32'h1);
        chk("mr_dout_9a", data_out, 32'h0000009A); chk("mr_mask_9a", 32'(byte_valid), 32'h1);

        // Randomized run against the byte-queue model (no back-pressure)
        m_bytes.delete(); m_cur = 2'd0; m_hold = 1'b0; m_drops = 0;
        exp_q.delete(); got_q.delete();
        cyc(1, 0, 0, 32'h0, 0, 0, 1);
        mon_on = 1'b1;
        model_on = 1'b1;
        begin
            logic [1:0] w;
            w = 2'd0;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 3) == 0) w = 2'($urandom_range(0, 3));
                cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), w, $urandom,
                    ($urandom_range(0, 6) == 0), 1'b0, 1'b0);
            end
        end
        cyc(1, 0, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0, 1, 0, 0);
        repeat (4) cyc(1, 0, 0, 32'h0, 0, 0, 0);
        model_on = 1'b0;
        mon_on = 1'b0;
        chk("rnd_words", got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            chk($sformatf("rnd%0d_dout", k), got_q[k][35:4], exp_q[k][35:4]);
            chk($sformatf("rnd%0d_mask", k), 32'(got_q[k][3:0]), 32'(exp_q[k][3:0]));
        end
        chk("rnd_cnt", 32'(drop_count), 32'(m_drops));
        chk("rnd_ovf", 32'(overflow), 32'(m_drops != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
